// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_d_sr;
  logic             r_br_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_br;
  logic [WIDTH-1:0] w_d_next;
  logic             w_accept;
  logic             w_last;

  // Full-subtractor cell on the current LSBs and the chained borrow.
  assign w_a0 = r_a_sr[0];
  assign w_b0 = r_b_sr[0];
  assign w_d  = w_a0 ^ w_b0 ^ r_br_q;
  assign w_br = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br_q);

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST);

  // A one-bit result register has no upper bits to shift down.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_d_next = w_d;
    end else begin : g_wn
      assign w_d_next = {w_d, r_d_sr[WIDTH-1:1]};
    end
  endgenerate

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: defaulting every combinational output first keeps this process
  // free of inferred latches on paths the case does not mention.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start)  w_next_state = SHIFT;
      SHIFT:   if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == SHIFT);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_d_sr <= '0;
      r_br_q <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a_sr <= a;
      r_b_sr <= b;
      r_br_q <= bin;
      r_cnt  <= '0;
    end else if (r_state == SHIFT) begin
      r_a_sr <= r_a_sr >> 1;
      r_b_sr <= r_b_sr >> 1;
      r_d_sr <= w_d_next;
      r_br_q <= w_br;
      r_cnt  <= r_cnt + 1'b1;
      // Results only move on the completing edge so they hold between ops.
      if (w_last) begin
        r_diff <= w_d_next;
        r_bout <= w_br;
      end
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a WIDTH=8 and a WIDTH=1 instance
// share clock and reset; expectations are queued at issue, checked on done.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    int         done_cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic       prev_rst  [2] = '{1'b1, 1'b1};
  logic [7:0] prev_diff [2] = '{8'h00, 8'h00};
  logic       prev_bout [2] = '{1'b0, 1'b0};
  int         busy_run  [2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle observation of one instance, sampled on the falling edge.
  task automatic mon(input int id, input logic busy, input logic done,
                     input logic [7:0] diff, input logic bout, input int width);
    exp_t  e;
    bit    have;
    string tag;
    tag = (id == 0) ? "w8" : "w1";
    if (prev_rst[id]) begin
      check({tag, "_rst_busy"}, busy, 0);
      check({tag, "_rst_done"}, done, 0);
      check({tag, "_rst_diff"}, diff, 0);
      check({tag, "_rst_bout"}, bout, 0);
      busy_run[id] = 0;
    end else begin
      check({tag, "_busy_done_excl"}, busy & done, 0);
      if (busy) busy_run[id]++;
      if (done) begin
        have = 1'b0;
        if (id == 0 && q8.size() > 0) begin e = q8.pop_front(); have = 1'b1; end
        if (id == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (!have) begin
          check({tag, "_unexpected_done"}, 1, 0);
        end else begin
          check({tag, "_diff"}, diff, e.diff);
          check({tag, "_bout"}, bout, e.bout);
          check({tag, "_done_cycle"}, cyc, e.done_cyc);
          check({tag, "_busy_len"}, busy_run[id], width);
        end
        busy_run[id] = 0;
      end else begin
        check({tag, "_diff_hold"}, diff, prev_diff[id]);
        check({tag, "_bout_hold"}, bout, prev_bout[id]);
      end
    end
    prev_diff[id] = diff;
    prev_bout[id] = bout;
    prev_rst[id]  = rst;
  endtask

  always @(negedge clk) begin
    mon(0, busy8, done8, diff8, bout8, 8);
    mon(1, busy1, done1, {7'b0, diff1}, bout1, 1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input bit push, input logic [7:0] ed, input logic eb);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    if (push) q8.push_back(exp_t'{ed, eb, cyc + 1 + 8});
    tick(1);
    start8 = 1'b0;
  endtask

  initial begin
    logic [8:0] r;
    logic [7:0] d1_tab;
    logic [7:0] b1_tab;
    logic [2:0] idx;
    int         waited;

    tick(3);
    rst = 1'b0;
    tick(2);

    // Basic operation and underflow / wrap-around vectors.
    go8(8'h5A, 8'h3C, 1'b0, 1, 8'h1E, 1'b0); tick(10);
    go8(8'h00, 8'h01, 1'b0, 1, 8'hFF, 1'b1); tick(10);
    go8(8'hFF, 8'hFF, 1'b1, 1, 8'hFF, 1'b1); tick(10);
    go8(8'h80, 8'h00, 1'b1, 1, 8'h7F, 1'b0); tick(10);

    // start re-pulsed during SHIFT must be ignored.
    go8(8'h33, 8'h11, 1'b0, 1, 8'h22, 1'b0); tick(2);
    go8(8'h77, 8'h99, 1'b1, 0, 8'h00, 1'b0); tick(2);
    go8(8'h01, 8'hF0, 1'b0, 0, 8'h00, 1'b0); tick(10);

    // Reset sampled on the edge ending the 4th SHIFT cycle aborts the op.
    go8(8'hF0, 8'h0F, 1'b0, 0, 8'h00, 1'b0);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(12);
    go8(8'h10, 8'h01, 1'b0, 1, 8'h0F, 1'b0); tick(10);

    // start held high for 40 cycles: accepted every 10 cycles.
    for (int i = 0; i < 40; i++) begin
      a8 = 8'(i * 37 + 5);
      b8 = 8'(i * 53 + 11);
      bin8 = i[0];
      start8 = 1'b1;
      if (i % 10 == 0) begin
        r = {1'b0, a8} - {1'b0, b8} - {8'b0, bin8};
        q8.push_back(exp_t'{r[7:0], r[8], cyc + 1 + 8});
      end
      tick(1);
    end
    start8 = 1'b0;
    tick(12);

    // WIDTH=1 full-subtractor truth table, index = {a, b, bin}.
    d1_tab = 8'b1001_0110;
    b1_tab = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      a1 = idx[2]; b1 = idx[1]; bin1 = idx[0];
      start1 = 1'b1;
      q1.push_back(exp_t'{{7'b0, d1_tab[idx]}, b1_tab[idx], cyc + 1 + 1});
      tick(1);
      start1 = 1'b0;
      tick(3);
    end

    waited = 0;
    while ((q8.size() + q1.size()) != 0 && waited < 50) begin
      tick(1);
      waited++;
    end
    check("pending_results", q8.size() + q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor that computes a − b − bin one bit per clock, LSB first, using a single full-subtractor cell (d = a^b^c, br = ~a&b | ~(a^b)&c) and a registered borrow. It sits directly downstream of the combinational full-subtractor cell. It consumes that cell's difference and borrow outputs every cycle, chaining the borrow through a flop and assembling the difference word in a shift register. Handshake is a start pulse in and a one-cycle done pulse out. It is the area-minimal alternative to the ripple-borrow parallel subtractor.

## Interface

- WIDTH, default 8: operand and result width in bits. Legal range is 1 to 32.

- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- start  input  1  request to begin an operation; honoured only in IDLE.
- a  input  WIDTH  minuend; sampled on the edge that accepts start.
- b  input  WIDTH  subtrahend; sampled on the edge that accepts start.
- bin  input  1  borrow-in; sampled on the edge that accepts start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  result (a − b − bin) mod 2^WIDTH; holds until the next completion.
- bout  output  1  final borrow; 1 iff unsigned a < b + bin.

## Operation

- Internal state: a_sr and b_sr (WIDTH-bit shift registers), d_sr (WIDTH-bit result shift register), br_q (borrow flop), cnt (bit counter, width clog2(WIDTH)+1), and the FSM.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - start=1 loads a_sr←a, b_sr←b, br_q←bin and cnt←0, then moves to SHIFT.
  - start=0 keeps the FSM in IDLE.
- SHIFT, each edge:
  - d = a_sr[0]^b_sr[0]^br_q.
  - br = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&br_q).
  - d_sr ← {d, d_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by 1.
  - br_q ← br.
  - cnt ← cnt+1.
- SHIFT exit: on the edge where cnt==WIDTH-1, after the final shift, diff←{d, d_sr[WIDTH-1:1]}, bout←br, and the FSM moves to DONE.
- DONE lasts exactly one cycle, with done=1. The next edge returns the FSM to IDLE unconditionally.
- start is ignored in SHIFT and DONE. The operation in flight is not disturbed and no request is queued.
- a, b and bin may change freely after the accepting edge.
- diff and bout change only on the completing edge. They are stable from the cycle done rises until the next completion.
- WIDTH=1: one SHIFT cycle, then DONE.

## Timing

- Reset values: busy=0, done=0, diff=0, bout=0. Internal state is FSM=IDLE, cnt=0, br_q=0, and all shift registers 0.
- rst has priority over every other input in every state.
- Reset mid-operation: the operation is aborted and no done pulse is produced. diff and bout clear to 0. The first start after rst deasserts is accepted normally.
- Latency, with E0 the edge that accepts start:
  - busy is high from the cycle after E0 for exactly WIDTH cycles.
  - done is high for one cycle, starting WIDTH cycles after E0.
- Throughput: one operation per WIDTH+2 cycles.
  - A start held high continuously is re-accepted in IDLE, i.e. on the edge ending the first IDLE cycle after DONE.
- done and busy are never high in the same cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan

All scenarios use WIDTH=8 unless noted.

- Reset, then a=8'h5A, b=8'h3C, bin=0 with a one-cycle start:
  - busy is high for exactly 8 cycles.
  - done pulses 8 cycles after the accepting edge.
  - diff=8'h1E, bout=0.
- Underflow and wrap-around:
  - a=8'h00, b=8'h01, bin=0 → diff=8'hFF, bout=1.
  - a=8'hFF, b=8'hFF, bin=1 → diff=8'hFF, bout=1.
  - a=8'h80, b=8'h00, bin=1 → diff=8'h7F, bout=0.
- start re-pulsed during busy with different operands: only one done is produced, and the result matches the first operands only. diff stays stable between done pulses.
- rst asserted on the 4th SHIFT cycle:
  - Next cycle: busy=0, diff=0, bout=0, and no done pulse ever appears.
  - A following start with a=8'h10, b=8'h01, bin=0 yields diff=8'h0F, bout=0.
- Back-to-back: start held high for 40 cycles.
  - done pulses are exactly 10 cycles apart.
  - Every result matches a model of (a − b − bin) mod 256, with borrow = (a < b+bin).
- WIDTH=1 build, exhaustive over the 8 combinations of a, b, bin:
  - Each result is d = a^b^bin and bout = ~a&b | ~(a^b)&bin, i.e. the full-subtractor truth table.
  - done pulses 1 cycle after the accepting edge.
